// File: rtl/bin_to_rns_9_8_7.sv
// Serial binary-to-RNS converter for moduli {9, 8, 7} (dynamic range 504).
// Residues mod 9 and mod 7 are reduced one bit per cycle, MSB first; mod 8 is the operand's low bits.
module bin_to_rns_9_8_7 (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [8:0] x_in,
  input  logic       x_valid_in,
  output logic       x_ready_out,
  output logic [3:0] a1_out,
  output logic [2:0] a2_out,
  output logic [2:0] a3_out,
  output logic       range_err_out,
  output logic       res_valid_out,
  input  logic       res_ready_in
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t     state;
  state_t     state_next;

  logic [8:0] shreg;
  logic [3:0] count;
  logic [3:0] r9;
  logic [2:0] r7;
  logic [2:0] a2_cap;
  logic       err_cap;

  logic       accept;
  logic       transfer;
  logic       bit_cur;
  logic [4:0] sum9;
  logic [4:0] sum7;
  logic [3:0] r9_next;
  logic [2:0] r7_next;

  assign x_ready_out   = (state == IDLE) & ~rst_in;
  assign res_valid_out = (state == DONE);
  assign accept        = x_valid_in & x_ready_out;
  assign transfer      = res_valid_out & res_ready_in;

  // The operand shifts left each BUSY cycle, so the bit being folded in is always the MSB.
  assign bit_cur = shreg[8];
  assign sum9    = {r9, 1'b0} + {4'b0000, bit_cur};
  assign sum7    = {1'b0, r7, 1'b0} + {4'b0000, bit_cur};
  assign r9_next = (sum9 >= 5'd9) ? 4'(sum9 - 5'd9) : sum9[3:0];
  assign r7_next = (sum7 >= 5'd7) ? 3'(sum7 - 5'd7) : sum7[2:0];

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (count == 4'd0) state_next = DONE;
      DONE:    if (transfer) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= IDLE;
      shreg         <= '0;
      count         <= '0;
      r9            <= '0;
      r7            <= '0;
      a2_cap        <= '0;
      err_cap       <= 1'b0;
      a1_out        <= '0;
      a2_out        <= '0;
      a3_out        <= '0;
      range_err_out <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && accept) begin
        shreg   <= x_in;
        count   <= 4'd8;
        r9      <= '0;
        r7      <= '0;
        a2_cap  <= x_in[2:0];
        err_cap <= (x_in >= 9'd504);
      end else if (state == BUSY) begin
        shreg <= {shreg[7:0], 1'b0};
        r9    <= r9_next;
        r7    <= r7_next;
        // Results are published only on the edge that folds in bit 0, so outputs stay stable otherwise.
        if (count == 4'd0) begin
          a1_out        <= r9_next;
          a2_out        <= a2_cap;
          a3_out        <= r7_next;
          range_err_out <= err_cap;
        end else begin
          count <= count - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bin_to_rns_9_8_7.sv
// Scoreboard bench for bin_to_rns_9_8_7: directed operands with hand-computed residues,
// backpressure, operand changes while busy and a reset that aborts a conversion.
module tb_bin_to_rns_9_8_7;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [8:0] x_in;
  logic       x_valid_in;
  logic       x_ready_out;
  logic [3:0] a1_out;
  logic [2:0] a2_out;
  logic [2:0] a3_out;
  logic       range_err_out;
  logic       res_valid_out;
  logic       res_ready_in;

  typedef struct {
    int x;
    int a1;
    int a2;
    int a3;
    int err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  bin_to_rns_9_8_7 dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .x_in         (x_in),
    .x_valid_in   (x_valid_in),
    .x_ready_out  (x_ready_out),
    .a1_out       (a1_out),
    .a2_out       (a2_out),
    .a3_out       (a3_out),
    .range_err_out(range_err_out),
    .res_valid_out(res_valid_out),
    .res_ready_in (res_ready_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_value(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every accepted result is popped and compared on the cycle it transfers.
  always @(negedge clk_in) begin
    exp_t e;
    if (!rst_in && res_valid_out && res_ready_in) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_result: got a1=%0d a2=%0d a3=%0d, expected no result",
                 a1_out, a2_out, a3_out);
      end else begin
        e = sb.pop_front();
        check_value($sformatf("a1 x=%0d", e.x), int'(a1_out), e.a1);
        check_value($sformatf("a2 x=%0d", e.x), int'(a2_out), e.a2);
        check_value($sformatf("a3 x=%0d", e.x), int'(a3_out), e.a3);
        check_value($sformatf("range_err x=%0d", e.x), int'(range_err_out), e.err);
      end
    end
  end

  task automatic apply_stimulus(input int x, input int a1, input int a2, input int a3,
                                input int err, input int stall, input bit junk);
    int lat;
    bit seen;
    @(posedge clk_in);
    #1;
    x_in         = 9'(x);
    x_valid_in   = 1'b1;
    res_ready_in = (stall == 0);
    @(negedge clk_in);
    check_value("ready_before_accept", int'(x_ready_out), 1);
    sb.push_back('{x, a1, a2, a3, err});
    @(posedge clk_in);
    #1;
    if (!junk) x_valid_in = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      if (junk) x_in = 9'($urandom);
      @(posedge clk_in);
      lat++;
      @(negedge clk_in);
      seen = res_valid_out;
    end
    check_value($sformatf("latency x=%0d", x), seen ? lat : -1, 9);
    for (int i = 0; i < stall; i++) begin
      check_value("held_valid", int'(res_valid_out), 1);
      check_value("held_a1", int'(a1_out), a1);
      check_value("held_a2", int'(a2_out), a2);
      check_value("held_a3", int'(a3_out), a3);
      check_value("held_err", int'(range_err_out), err);
      @(posedge clk_in);
      #1;
      if (i == stall - 1) res_ready_in = 1'b1;
      @(negedge clk_in);
    end
    @(posedge clk_in);
    #1;
    x_valid_in   = 1'b0;
    x_in         = '0;
    res_ready_in = 1'b1;
    @(negedge clk_in);
    check_value("ready_after_transfer", int'(x_ready_out), 1);
    check_value("valid_after_transfer", int'(res_valid_out), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hit;
    rst_in       = 1'b1;
    x_in         = '0;
    x_valid_in   = 1'b0;
    res_ready_in = 1'b0;
    repeat (2) @(negedge clk_in);
    check_value("ready_in_reset", int'(x_ready_out), 0);
    check_value("valid_in_reset", int'(res_valid_out), 0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    @(negedge clk_in);
    check_value("reset_a1", int'(a1_out), 0);
    check_value("reset_a2", int'(a2_out), 0);
    check_value("reset_a3", int'(a3_out), 0);
    check_value("reset_err", int'(range_err_out), 0);
    check_value("ready_after_reset", int'(x_ready_out), 1);

    apply_stimulus(0,   0, 0, 0, 0, 0, 1'b0);
    apply_stimulus(503, 8, 7, 6, 0, 0, 1'b0);
    apply_stimulus(100, 1, 4, 2, 0, 0, 1'b0);
    apply_stimulus(504, 0, 0, 0, 1, 0, 1'b0);
    apply_stimulus(1,   1, 1, 1, 0, 0, 1'b0);
    apply_stimulus(9,   0, 1, 2, 0, 0, 1'b0);
    apply_stimulus(255, 3, 7, 3, 0, 0, 1'b1);
    apply_stimulus(256, 4, 0, 4, 0, 0, 1'b1);
    apply_stimulus(448, 7, 0, 0, 0, 2, 1'b0);
    apply_stimulus(250, 7, 2, 5, 0, 5, 1'b0);
    apply_stimulus(505, 1, 1, 1, 1, 0, 1'b0);
    apply_stimulus(510, 6, 6, 6, 1, 0, 1'b0);
    apply_stimulus(511, 7, 7, 0, 1, 0, 1'b0);

    // Abort a conversion mid-flight; its result must never appear.
    @(posedge clk_in);
    #1;
    x_in       = 9'd300;
    x_valid_in = 1'b1;
    @(posedge clk_in);
    #1;
    x_valid_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    @(negedge clk_in);
    check_value("abort_valid", int'(res_valid_out), 0);
    check_value("abort_a1", int'(a1_out), 0);
    check_value("abort_a2", int'(a2_out), 0);
    check_value("abort_a3", int'(a3_out), 0);
    check_value("abort_err", int'(range_err_out), 0);
    check_value("abort_ready", int'(x_ready_out), 1);
    hit = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_in);
      if (res_valid_out) hit = 1;
    end
    check_value("abort_no_result", hit, 0);

    apply_stimulus(13, 4, 5, 6, 0, 0, 1'b0);

    repeat (20) @(negedge clk_in);
    check_value("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bin_to_rns_9_8_7.md
BIN_TO_RNS_9_8_7 -- requirements
Module: bin_to_rns_9_8_7

Interface
REQ-001 Parameters: none; moduli fixed at 9, 8, 7, dynamic range M = 504.
REQ-002 clk_in  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_in  input  1  reset, synchronous and active-high.
REQ-004 x_in  input  9  unsigned binary operand, sampled on the accept edge.
REQ-005 x_valid_in  input  1  x_in valid.
REQ-006 x_ready_out  output  1  block can accept an operand.
REQ-007 a1_out  output  4  residue x mod 9, range 0..8.
REQ-008 a2_out  output  3  residue x mod 8, range 0..7.
REQ-009 a3_out  output  3  residue x mod 7, range 0..6 (canonical; 7 never driven).
REQ-010 range_err_out  output  1  captured x_in >= 504; residues then encode x_in mod 504.
REQ-011 res_valid_out  output  1  residues and range_err_out valid.
REQ-012 res_ready_in  input  1  downstream (the 9/8/7 RNS comparator's operand register) accepts the result.

Function
REQ-013 FSM states IDLE, BUSY, DONE; accept = x_valid_in & x_ready_out; transfer = res_valid_out & res_ready_in.
REQ-014 x_ready_out = (state == IDLE) & ~rst_in; res_valid_out = (state == DONE).
REQ-015 Transitions:
- IDLE -> BUSY on accept: load shift register with x_in, bit counter = 8, both residue accumulators = 0, range_err = (x_in >= 504).
- BUSY -> DONE on the edge that processes bit 0.
- DONE -> IDLE on transfer.
- All other cycles: hold state.
REQ-016 BUSY processes one bit per cycle, MSB first, bit index = counter:
- r9 <= (2*r9 + b) - 9 when (2*r9 + b) >= 9, else (2*r9 + b).
- r7 <= (2*r7 + b) - 7 when (2*r7 + b) >= 7, else (2*r7 + b).
- Internal sums are at least 5 bits wide, no overflow.
REQ-017 a2 = captured x_in[2:0], available without serial reduction.
REQ-018 Latency: res_valid_out rises exactly 9 cycles after the accept edge; BUSY lasts exactly 9 cycles.
REQ-019 While res_valid_out = 1 and res_ready_in = 0, a1_out, a2_out, a3_out and range_err_out stay stable.
REQ-020 Outputs are registered; in IDLE and BUSY they hold the last delivered result (0 after reset) and change only on the BUSY->DONE edge.
REQ-021 No overlap: x_ready_out = 0 in BUSY and DONE; x_valid_in is ignored there.
REQ-022 Transfer and a new accept cannot share a cycle; the earliest next accept is the cycle after transfer; peak throughput is 1 result per 11 cycles.
REQ-023 x_in values 504..511 are still converted; range_err_out = 1 for such a result and 0 otherwise.
REQ-024 res_ready_in in IDLE/BUSY and x_valid_in outside IDLE produce no state change.

Reset
REQ-025 While rst_in = 1 at an edge:
- state <= IDLE.
- res_valid_out, range_err_out, a1_out, a2_out, a3_out, counter, accumulators <= 0.
- x_ready_out = 0.
REQ-026 Reset asserted in BUSY or DONE discards the operation; no result is delivered afterwards.
REQ-027 First accept is possible on the first edge with rst_in = 0.

Verification
REQ-028 x_in=0 accepted, res_ready_in=1 -> 9 cycles later res_valid_out=1, (a1,a2,a3)=(0,0,0), range_err_out=0, next cycle IDLE.
REQ-029 x_in=503 -> (8,7,6), range_err_out=0; x_in=100 -> (1,4,2); x_in=504 -> (0,0,0), range_err_out=1; x_in=511 -> (7,7,0), range_err_out=1.
REQ-030 x_in=250, res_ready_in=0 for 5 cycles after valid -> (7,2,5) held stable for all 5 cycles; transfer on cycle 6; x_ready_out=1 the following cycle.
REQ-031 rst_in pulsed 1 cycle at BUSY cycle 4 -> res_valid_out never rises for that operand; outputs all 0; a new x_in=13 then yields (4,5,6) with latency 9.
REQ-032 Exhaustive sweep x_in=0..511, random backpressure -> every result matches (x mod 9, x mod 8, x mod 7) and range_err; feeding pairs into compare_9_8_7 matches the binary ordering for x < 504.
REQ-033 x_valid_in held 1 with changing x_in during BUSY/DONE -> result reflects only the accepted value; no extra accept occurs.
